rr_arb4: RTL and testbench

Four-requester round-robin arbiter that shares a single instance of the team's 4-to-2 case-based encoder datapath (or any single-owner resource) among four clients. It samples a 4-bit request vector, uses a rotating-priority encode to select one owner, and holds the grant until the owner releases the resource or a hold-timeout expires. It sits between the client request lines and the shared resource's select/enable inputs.

---
 rtl/rr_arb4_pkg.sv | 15 +
 rtl/rr_prio_enc.sv | 36 +++
 rtl/rr_arb4.sv | 80 ++++++++
 tb/tb_rr_arb4.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the four-client round-robin arbiter.
package rr_arb4_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational rotating-priority encoder: first set request at or after ptr, wrapping 3->0.
module rr_prio_enc
    import rr_arb4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    output logic             any,
    output logic [1:0]       idx
);

    logic [N_REQ-1:0] rot;
    logic [1:0]       off;

    // rot[0] is the highest-priority client, so a fixed-priority case does the search.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[2'(ptr + 2'(i))];
        end
    end

    always_comb begin
        any = 1'b1;
        off = 2'd0;
        casez (rot)
            4'b???1: off = 2'd0;
            4'b??10: off = 2'd1;
            4'b?100: off = 2'd2;
            4'b1000: off = 2'd3;
            default: any = 1'b0;
        endcase
    end

    assign idx = ptr + off;

endmodule

// File: rtl/rr_arb4.sv
// Round-robin arbiter for one single-owner resource shared by four clients.
// Grant appears one cycle after a request in IDLE; release forces a one-cycle idle gap.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             gnt_valid,
    output logic [1:0]       gnt_idx,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] LAST_CNT = HOLD_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);

    state_t            state;
    logic [1:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic       win_any;
    logic [1:0] win_idx;
    logic       withdraw;
    logic       hold_expired;
    logic       release_now;

    rr_prio_enc u_prio_enc (
        .req (req),
        .ptr (ptr),
        .any (win_any),
        .idx (win_idx)
    );

    assign withdraw     = !req[gnt_idx];
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == LAST_CNT);
    assign release_now  = done || withdraw || hold_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= 2'd0;
            hold_cnt   <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= 2'd0;
            gnt_onehot <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= win_idx;
                        gnt_onehot <= idx_to_onehot(win_idx);
                        hold_cnt   <= '0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (release_now) begin
                        gnt_valid  <= 1'b0;
                        gnt_onehot <= '0;
                        ptr        <= gnt_idx + 2'd1;
                        state      <= ST_IDLE;
                        // Only flag a revocation the owner did not ask for itself.
                        timeout    <= hold_expired && !done && !withdraw;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb4.sv
// Directed bench for rr_arb4 with a cycle-level reference model and literal spot checks.
module tb_rr_arb4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [3:0] gnt_onehot;
    logic       timeout;

    int checks = 0;
    int failures = 0;

    rr_arb4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Model: owner (-1 = none), next-priority client, and how many cycles the grant has been shown.
    int   m_owner = -1;
    int   m_ptr = 0;
    int   m_shown = 0;
    int   m_last = 0;
    bit   m_to = 0;
    bit   m_ready = 0;

    always @(posedge clk) begin
        m_ready = 1;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_shown = 0; m_last = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c; m_last = c; m_shown = 1;
                end
            end
        end else begin
            bit quit, expired;
            quit    = done || !req[m_owner];
            expired = (m_shown == MAX_HOLD);
            if (quit || expired) begin
                m_to    = expired && !quit;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_to = 0;
                m_shown++;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Packed view {valid, idx, onehot, timeout}.
    function automatic logic [7:0] model_out();
        logic [3:0] oh;
        oh = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        return {(m_owner >= 0), 2'(m_last), oh, m_to};
    endfunction

    always @(negedge clk) begin
        if (m_ready) check("model", {gnt_valid, gnt_idx, gnt_onehot, timeout}, model_out());
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (gnt_valid !== 1'b1 && n < 10) begin
            cyc(1);
            n++;
        end
        if (gnt_valid !== 1'b1) check(name, {7'd0, gnt_valid}, 8'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        cyc(1);
        rst = 1'b0;
    endtask

    int grants[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int cnt;

    initial begin
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("reset_outputs", {gnt_valid, gnt_idx, gnt_onehot, timeout}, 8'h00);

        // Idle noise
        done = 1'b1; cyc(1); done = 1'b0; cyc(1);
        check("idle_done_noise", {gnt_valid, gnt_idx, gnt_onehot, timeout}, 8'h00);

        // Fairness
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant("fair_wait");
            grants.push_back(int'(gnt_idx));
            done = 1'b1; cyc(1); done = 1'b0;
            check("fair_gap", {7'd0, gnt_valid}, 8'd0);
        end
        for (int g = 0; g < 5; g++) check("fair_seq", 8'(grants[g]), 8'(exp_seq[g]));
        req = 4'b0000; cyc(2);

        // Wrap
        do_reset();
        req = 4'b0100; cyc(1);
        check("wrap_first", {gnt_valid, gnt_idx, gnt_onehot, 1'b0}, {1'b1, 2'd2, 4'b0100, 1'b0});
        done = 1'b1; cyc(1); done = 1'b0;
        req = 4'b0101; cyc(1);
        check("wrap_second", {gnt_valid, gnt_idx, gnt_onehot, 1'b0}, {1'b1, 2'd0, 4'b0001, 1'b0});
        done = 1'b1; cyc(1); done = 1'b0; req = 4'b0000; cyc(2);

        // Timeout
        do_reset();
        req = 4'b0010; cyc(1);
        cnt = 0;
        while (gnt_valid === 1'b1 && cnt < 20) begin
            cnt++;
            cyc(1);
        end
        check("timeout_hold_len", 8'(cnt), 8'd8);
        check("timeout_pulse", {7'd0, timeout}, 8'd1);
        req = 4'b1111; cyc(1);
        check("timeout_ptr", {6'd0, gnt_idx}, 8'd2);
        check("timeout_one_cycle", {7'd0, timeout}, 8'd0);

        // Withdraw mid-hold
        cyc(2);
        req = 4'b1011; cyc(1);
        check("withdraw_release", {6'd0, gnt_valid, timeout}, 8'd0);
        cyc(1);
        check("withdraw_next", {gnt_valid, gnt_idx, 5'd0}, {1'b1, 2'd3, 5'd0});
        req = 4'b0000; cyc(2);

        // done coincident with the final hold cycle
        req = 4'b0001; cyc(1);
        cyc(MAX_HOLD - 1);
        check("tie_still_held", {7'd0, gnt_valid}, 8'd1);
        done = 1'b1; cyc(1); done = 1'b0;
        check("tie_no_timeout", {6'd0, gnt_valid, timeout}, 8'd0);
        req = 4'b0000; cyc(2);

        // Reset while busy
        do_reset();
        req = 4'b1000; cyc(1);
        check("rst_owner3", {gnt_valid, gnt_idx, gnt_onehot, 1'b0}, {1'b1, 2'd3, 4'b1000, 1'b0});
        cyc(2);
        rst = 1'b1; cyc(1);
        check("rst_mid_op", {gnt_valid, gnt_idx, gnt_onehot, timeout}, 8'h00);
        rst = 1'b0; req = 4'b1010; cyc(1);
        check("rst_ptr_restored", {gnt_valid, gnt_idx, gnt_onehot, 1'b0}, {1'b1, 2'd1, 4'b0010, 1'b0});
        done = 1'b1; cyc(1); done = 1'b0; req = 4'b0000; cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
